// File: rtl/j4_io_hub.sv
// IO-side responder for the four-slot barrel core: per-slot mailboxes,
// a free-running cycle counter and the slot-kill request generator.
module j4_io_hub #(
    parameter int WIDTH      = 16,
    parameter int MBOX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [1:0]       io_slot,
    input  logic [15:0]      mem_addr,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] io_din,
    output logic [3:0]       kill_slot_rq,
    output logic [3:0]       mbox_nonempty
);

    localparam int PTR_W = $clog2(MBOX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [4][MBOX_DEPTH];
    logic [PTR_W-1:0] rd_ptr [4];
    logic [PTR_W-1:0] wr_ptr [4];
    logic [CNT_W-1:0] count [4];
    logic [CNT_W-1:0] count_next [4];
    logic [1:0]       kill_cnt [4];
    logic [3:0]       overflow;
    logic [3:0]       full;
    logic [3:0]       push_en;
    logic [3:0]       push_drop;
    logic [3:0]       pop_en;
    logic [3:0]       kill_sel;
    logic [15:0]      cycle_cnt;
    logic [15:0]      cnt_wide;
    logic [15:0]      status_word;
    logic             rd_only;
    logic             hit_push;
    logic             hit_pop;
    logic             hit_stat;
    logic             kill_wr;

    // A combined read+write keeps the write but drops read side effects.
    assign rd_only  = io_rd & ~io_wr;
    assign hit_push = io_wr && (mem_addr[15:2] == 14'h0400);
    assign hit_pop  = rd_only && (mem_addr == 16'h1000);
    assign hit_stat = rd_only && (mem_addr == 16'h1004);
    assign kill_wr  = io_wr && (mem_addr == 16'h2000) && (io_slot == 2'd0);
    assign kill_sel = kill_wr ? {dout[3:1], 1'b0} : 4'b0000;

    always_comb begin
        full       = '0;
        push_en    = '0;
        push_drop  = '0;
        pop_en     = '0;
        count_next = count;
        for (int t = 0; t < 4; t++) begin
            full[t]      = (count[t] == CNT_W'(MBOX_DEPTH));
            push_en[t]   = hit_push && (mem_addr[1:0] == 2'(t)) && !full[t];
            push_drop[t] = hit_push && (mem_addr[1:0] == 2'(t)) && full[t];
            pop_en[t]    = hit_pop && (io_slot == 2'(t)) && (count[t] != '0);
            if (kill_sel[t])
                count_next[t] = '0;
            else if (push_en[t])
                count_next[t] = count[t] + 1'b1;
            else if (pop_en[t])
                count_next[t] = count[t] - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < 4; t++) begin
                rd_ptr[t]   <= '0;
                wr_ptr[t]   <= '0;
                count[t]    <= '0;
                kill_cnt[t] <= '0;
            end
            overflow      <= '0;
            kill_slot_rq  <= '0;
            mbox_nonempty <= '0;
            cycle_cnt     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            for (int t = 0; t < 4; t++) begin
                count[t]         <= count_next[t];
                mbox_nonempty[t] <= (count_next[t] != '0);
                if (kill_sel[t]) begin
                    rd_ptr[t]   <= '0;
                    wr_ptr[t]   <= '0;
                    overflow[t] <= 1'b0;
                end else begin
                    if (push_en[t])
                        wr_ptr[t] <= wr_ptr[t] + 1'b1;
                    if (pop_en[t])
                        rd_ptr[t] <= rd_ptr[t] + 1'b1;
                    if (push_drop[t])
                        overflow[t] <= 1'b1;
                    else if (hit_stat && (io_slot == 2'(t)))
                        overflow[t] <= 1'b0;
                end
                // Load 3 and count down to 0 so the request spans one full rotation.
                if (kill_sel[t]) begin
                    kill_cnt[t]     <= 2'd3;
                    kill_slot_rq[t] <= 1'b1;
                end else if (kill_slot_rq[t]) begin
                    if (kill_cnt[t] == 2'd0)
                        kill_slot_rq[t] <= 1'b0;
                    else
                        kill_cnt[t] <= kill_cnt[t] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int t = 0; t < 4; t++) begin
            if (push_en[t])
                mem[t][wr_ptr[t]] <= dout;
        end
    end

    always_comb begin
        cnt_wide    = 16'(count[io_slot]);
        status_word = '0;
        status_word[2:0]  = (cnt_wide > 16'd7) ? 3'd7 : cnt_wide[2:0];
        status_word[4]    = overflow[io_slot];
        status_word[11:8] = full;
        io_din = '0;
        if (io_rd) begin
            case (mem_addr)
                16'h1000: if (count[io_slot] != '0) io_din = mem[io_slot][rd_ptr[io_slot]];
                16'h1004: io_din = WIDTH'(status_word);
                16'h2001: io_din = WIDTH'(cycle_cnt);
                default:  io_din = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_j4_io_hub.sv
// Self-checking bench for j4_io_hub: a per-slot mailbox model acts as the
// scoreboard, filled on pushes and drained when the DUT answers a pop.
module tb_j4_io_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_rd;
    logic        io_wr;
    logic [1:0]  io_slot;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;
    logic [3:0]  kill_slot_rq;
    logic [3:0]  mbox_nonempty;

    logic [15:0] model_q [4][$];
    logic [3:0]  model_ovf;
    logic [15:0] last_din;
    logic [15:0] v1;
    logic [15:0] v2;
    int          checks = 0;
    int          errors = 0;

    j4_io_hub #(.WIDTH(16), .MBOX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
        .io_slot(io_slot), .mem_addr(mem_addr), .dout(dout),
        .io_din(io_din), .kill_slot_rq(kill_slot_rq), .mbox_nonempty(mbox_nonempty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%h, expected 0x%h", tag, observed, expected);
        end
    endtask

    // One IO operation per cycle: drive at negedge, sample io_din before the edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] slot,
                                 input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        io_rd = rd; io_wr = wr; io_slot = slot; mem_addr = addr; dout = data;
        #1 last_din = io_din;
        @(posedge clk);
        #1;
        io_rd = 1'b0; io_wr = 1'b0;
    endtask

    task automatic pushWord(input logic [1:0] src, input logic [1:0] target, input logic [15:0] data);
        applyStimulus(1'b0, 1'b1, src, 16'h1000 + 16'(target), data);
        if (model_q[target].size() < 4) model_q[target].push_back(data);
        else model_ovf[target] = 1'b1;
    endtask

    task automatic popCheck(input logic [1:0] slot, input string tag);
        logic [15:0] exp_v;
        applyStimulus(1'b1, 1'b0, slot, 16'h1000, 16'h0);
        exp_v = (model_q[slot].size() != 0) ? model_q[slot].pop_front() : 16'h0000;
        checkOutput(tag, last_din, exp_v);
    endtask

    function automatic logic [15:0] expStatus(input logic [1:0] slot);
        logic [15:0] s;
        s = 16'(model_q[slot].size());
        s[4] = model_ovf[slot];
        for (int t = 0; t < 4; t++) s[8 + t] = (model_q[t].size() == 4);
        return s;
    endfunction

    task automatic statusCheck(input logic [1:0] slot, input string tag);
        logic [15:0] exp_v;
        exp_v = expStatus(slot);
        applyStimulus(1'b1, 1'b0, slot, 16'h1004, 16'h0);
        model_ovf[slot] = 1'b0;
        checkOutput(tag, last_din, exp_v);
    endtask

    task automatic clearModel();
        for (int t = 0; t < 4; t++) model_q[t].delete();
        model_ovf = '0;
    endtask

    initial begin
        int n;
        reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_slot = 2'd0; mem_addr = 16'h0; dout = 16'h0;
        clearModel();
        #1;
        checkOutput("reset_kill", 16'(kill_slot_rq), 16'h0);
        checkOutput("reset_nonempty", 16'(mbox_nonempty), 16'h0);
        checkOutput("reset_din", io_din, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Mailbox FIFO order and empty read
        pushWord(2'd2, 2'd1, 16'h1234);
        pushWord(2'd2, 2'd1, 16'h5678);
        checkOutput("nonempty1_set", 16'(mbox_nonempty[1]), 16'h1);
        popCheck(2'd1, "pop1_a");
        popCheck(2'd1, "pop1_b");
        popCheck(2'd1, "pop1_empty");
        checkOutput("nonempty1_clr", 16'(mbox_nonempty[1]), 16'h0);

        // Overflow on slot 3
        for (int k = 1; k <= 5; k++) pushWord(2'd0, 2'd3, 16'(k * 16'h1111));
        statusCheck(2'd3, "status3_ovf");
        checkOutput("status3_literal", last_din, 16'h0814);
        statusCheck(2'd3, "status3_cleared");
        popCheck(2'd3, "pop3_first");

        // Kill slots 1 and 3 with data queued; dout[0] set but ignored
        pushWord(2'd0, 2'd1, 16'hC001);
        pushWord(2'd0, 2'd1, 16'hC002);
        pushWord(2'd0, 2'd2, 16'hD001);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h2000, 16'h000B);
        model_q[1].delete(); model_q[3].delete();
        model_ovf[1] = 1'b0; model_ovf[3] = 1'b0;
        checkOutput("kill_nonempty", 16'(mbox_nonempty), 16'h0004);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("kill_win%0d", i), 16'(kill_slot_rq), (i < 4) ? 16'h000A : 16'h0000);
        end
        statusCheck(2'd1, "status1_flushed");
        statusCheck(2'd3, "status3_flushed");
        popCheck(2'd2, "pop2_kept");
        applyStimulus(1'b0, 1'b1, 2'd2, 16'h2000, 16'h000A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("kill_bad_slot%0d", i), 16'(kill_slot_rq), 16'h0000);
        end

        // Kill restart extends the window
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h2000, 16'h0002);
        @(negedge clk); @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h2000, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("kill_restart%0d", i), 16'(kill_slot_rq), (i < 4) ? 16'h0002 : 16'h0000);
        end

        // Cycle counter delta and wrap
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h2001, 16'h0);
        v1 = last_din;
        repeat (3) @(posedge clk);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h2001, 16'h0);
        v2 = last_din;
        checkOutput("counter_delta", v2 - v1, 16'd4);
        n = 32'h10000 - int'(v2);
        repeat (n - 1) @(posedge clk);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h2001, 16'h0);
        checkOutput("counter_wrap", last_din, 16'h0000);

        // Read+write together: write wins, pop suppressed
        pushWord(2'd0, 2'd0, 16'hAAAA);
        applyStimulus(1'b1, 1'b1, 2'd0, 16'h1000, 16'hBBBB);
        checkOutput("rdwr_peek", last_din, model_q[0][0]);
        model_q[0].push_back(16'hBBBB);
        popCheck(2'd0, "rdwr_pop_a");
        popCheck(2'd0, "rdwr_pop_b");
        popCheck(2'd0, "rdwr_pop_empty");
        applyStimulus(1'b1, 1'b0, 2'd1, 16'h3000, 16'h0);
        checkOutput("unmapped_rd", last_din, 16'h0000);

        // Asynchronous reset in the middle of a kill window
        pushWord(2'd1, 2'd2, 16'hE001);
        pushWord(2'd1, 2'd0, 16'hE002);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h2000, 16'h0004);
        @(negedge clk);
        checkOutput("midkill_active", 16'(kill_slot_rq), 16'h0004);
        #2 reset = 1'b1;
        #1;
        checkOutput("midkill_reset_kill", 16'(kill_slot_rq), 16'h0000);
        checkOutput("midkill_reset_nonempty", 16'(mbox_nonempty), 16'h0000);
        clearModel();
        @(negedge clk) reset = 1'b0;
        for (int t = 0; t < 4; t++) statusCheck(2'(t), $sformatf("post_reset_status%0d", t));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
